// File: rtl/karatsuba_seq_ctrl_if.sv
// Bundles the operand, result and shared-multiplier handshakes of the Karatsuba controller.
// Latency: none (wires only).
// Backpressure: valid/ready on operand, result and request channels; response channel has none.
interface karatsuba_seq_ctrl_if #(
    parameter int N = 16
);
    localparam int H = N / 2 + N % 2;

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_u;
    logic [N-1:0]     in_v;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   out_r;
    logic             mul_req_valid;
    logic             mul_req_ready;
    logic [H:0]       mul_u;
    logic [H:0]       mul_v;
    logic             mul_rsp_valid;
    logic [2*H+1:0]   mul_rsp_r;

    // Environment side: operand producer, result consumer and shared multiplier
    modport master (
        output in_valid, in_u, in_v, out_ready, mul_req_ready, mul_rsp_valid, mul_rsp_r,
        input  in_ready, out_valid, out_r, mul_req_valid, mul_u, mul_v
    );

    // Controller side
    modport slave (
        input  in_valid, in_u, in_v, out_ready, mul_req_ready, mul_rsp_valid, mul_rsp_r,
        output in_ready, out_valid, out_r, mul_req_valid, mul_u, mul_v
    );
endinterface

// File: rtl/karatsuba_seq_ctrl.sv
// Sequential N x N Karatsuba multiplier issuing x=a*c, y=b*d, z=(a+b)*(c+d) to one shared multiplier.
// Latency: 8 cycles accept-to-out_valid with an ideal multiplier, +1 per request stall or response delay cycle.
// Backpressure: one operation in flight; in_ready only in IDLE; result held in DONE until out_ready.
module karatsuba_seq_ctrl #(
    parameter int N = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    karatsuba_seq_ctrl_if.slave  bus
);
    localparam int H = N / 2 + N % 2;
    localparam int L = N - H;

    typedef enum logic [3:0] {
        IDLE, MUL_X, WAIT_X, MUL_Y, WAIT_Y, MUL_Z, WAIT_Z, COMBINE, DONE
    } state_t;

    state_t           state_q, state_d;
    logic [L-1:0]     a_q, a_d, c_q, c_d;
    logic [H-1:0]     b_q, b_d, d_q, d_d;
    logic [2*L-1:0]   x_q, x_d;
    logic [2*H-1:0]   y_q, y_d;
    logic [2*H+1:0]   z_q, z_d;
    logic [2*N-1:0]   r_q, r_d;
    logic             out_vld_q, out_vld_d;

    logic [H:0]       a_ext, b_ext, c_ext, d_ext;
    logic [2*H+1:0]   x_ext, y_ext, s_w;
    logic [2*N-1:0]   x_wide, s_wide, y_wide;

    // Zero-extend halves and sub-products; middle term s = z - x - y (= a*d + b*c, never negative)
    always_comb begin
        a_ext  = '0;  a_ext[L-1:0]    = a_q;
        c_ext  = '0;  c_ext[L-1:0]    = c_q;
        b_ext  = '0;  b_ext[H-1:0]    = b_q;
        d_ext  = '0;  d_ext[H-1:0]    = d_q;
        x_ext  = '0;  x_ext[2*L-1:0]  = x_q;
        y_ext  = '0;  y_ext[2*H-1:0]  = y_q;
        s_w    = z_q - x_ext - y_ext;
        x_wide = '0;  x_wide[2*L-1:0] = x_q;
        s_wide = '0;  s_wide[2*H+1:0] = s_w;
        y_wide = '0;  y_wide[2*H-1:0] = y_q;
    end

    // State, operand, sub-product and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            r_q       <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            d_q       <= d_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            r_q       <= r_d;
            out_vld_q <= out_vld_d;
        end
    end

    // Next-state sequencing: request, wait for its response, then the next sub-product
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)      state_d = MUL_X;
            MUL_X:   if (bus.mul_req_ready) state_d = WAIT_X;
            WAIT_X:  if (bus.mul_rsp_valid) state_d = MUL_Y;
            MUL_Y:   if (bus.mul_req_ready) state_d = WAIT_Y;
            WAIT_Y:  if (bus.mul_rsp_valid) state_d = MUL_Z;
            MUL_Z:   if (bus.mul_req_ready) state_d = WAIT_Z;
            WAIT_Z:  if (bus.mul_rsp_valid) state_d = COMBINE;
            COMBINE:                        state_d = DONE;
            DONE:    if (bus.out_ready)     state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // Datapath captures; responses are only taken in the matching WAIT state
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        d_d = d_q;
        x_d = x_q;
        y_d = y_q;
        z_d = z_q;
        r_d = r_q;
        if (state_q == IDLE && bus.in_valid) begin
            a_d = bus.in_u[N-1:H];
            b_d = bus.in_u[H-1:0];
            c_d = bus.in_v[N-1:H];
            d_d = bus.in_v[H-1:0];
        end
        if (state_q == WAIT_X && bus.mul_rsp_valid) x_d = bus.mul_rsp_r[2*L-1:0];
        if (state_q == WAIT_Y && bus.mul_rsp_valid) y_d = bus.mul_rsp_r[2*H-1:0];
        if (state_q == WAIT_Z && bus.mul_rsp_valid) z_d = bus.mul_rsp_r;
        if (state_q == COMBINE) r_d = (x_wide << (2 * H)) + (s_wide << H) + y_wide;
        out_vld_d = (state_d == DONE);
    end

    // Outputs decode from registered state only, so request operands hold while stalled
    always_comb begin
        bus.in_ready      = (state_q == IDLE);
        bus.mul_req_valid = 1'b0;
        bus.mul_u         = '0;
        bus.mul_v         = '0;
        case (state_q)
            MUL_X: begin
                bus.mul_req_valid = 1'b1;
                bus.mul_u         = a_ext;
                bus.mul_v         = c_ext;
            end
            MUL_Y: begin
                bus.mul_req_valid = 1'b1;
                bus.mul_u         = b_ext;
                bus.mul_v         = d_ext;
            end
            MUL_Z: begin
                bus.mul_req_valid = 1'b1;
                bus.mul_u         = a_ext + b_ext;
                bus.mul_v         = c_ext + d_ext;
            end
            default: ;
        endcase
        bus.out_valid = out_vld_q;
        bus.out_r     = r_q;
    end
endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// Randomized bench for karatsuba_seq_ctrl (N=16 and N=7) against a plain u*v product model.
// Latency: checked against 8 + request stalls + 3 x response delay.
// Backpressure: exercises mul_req_ready stalls, delayed responses and out_ready holds.
module tb_karatsuba_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    karatsuba_seq_ctrl_if #(.N(16)) m16 ();
    karatsuba_seq_ctrl_if #(.N(7))  m7  ();

    karatsuba_seq_ctrl #(.N(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(m16.slave));
    karatsuba_seq_ctrl #(.N(7))  dut7  (.clk(clk), .rst_n(rst_n), .bus(m7.slave));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- shared multiplier model for N=16 ----------------
    int          stall16 = 0;
    int          dly16   = 0;
    int          cnt16   = 0;
    bit          acc16   = 0;
    bit          pend16  = 0;
    bit          stalled16 = 0;
    logic [17:0] prod16  = '0;
    logic [8:0]  pu16    = '0;
    logic [8:0]  pv16    = '0;
    logic [8:0]  rq_u[$];
    logic [8:0]  rq_v[$];

    initial begin
        m16.mul_req_ready = 1'b0;
        m16.mul_rsp_valid = 1'b0;
        m16.mul_rsp_r     = '0;
        forever begin
            @(posedge clk); #1;
            m16.mul_rsp_valid = 1'b0;
            m16.mul_rsp_r     = 18'($urandom);
            if (acc16) begin
                pend16 = 1;
                cnt16  = dly16;
            end
            if (pend16) begin
                if (cnt16 == 0) begin
                    m16.mul_rsp_valid = 1'b1;
                    m16.mul_rsp_r     = prod16;
                    pend16            = 0;
                end else begin
                    cnt16--;
                end
            end
            if (stalled16 && m16.mul_req_valid) begin
                chk("mul_u_stable", 64'(m16.mul_u), 64'(pu16));
                chk("mul_v_stable", 64'(m16.mul_v), 64'(pv16));
            end
            if (m16.mul_req_valid && stall16 > 0) begin
                m16.mul_req_ready = 1'b0;
                stall16--;
            end else begin
                m16.mul_req_ready = 1'b1;
            end
            stalled16 = m16.mul_req_valid && !m16.mul_req_ready;
            pu16      = m16.mul_u;
            pv16      = m16.mul_v;
            acc16     = m16.mul_req_valid && m16.mul_req_ready;
            if (acc16) begin
                prod16 = pu16 * pv16;
                rq_u.push_back(pu16);
                rq_v.push_back(pv16);
            end
        end
    end

    // ---------------- ideal multiplier model for N=7 ----------------
    bit          acc7  = 0;
    logic [9:0]  prod7 = '0;
    logic [4:0]  q7u[$];
    logic [4:0]  q7v[$];

    initial begin
        m7.mul_req_ready = 1'b0;
        m7.mul_rsp_valid = 1'b0;
        m7.mul_rsp_r     = '0;
        forever begin
            @(posedge clk); #1;
            m7.mul_rsp_valid = acc7;
            m7.mul_rsp_r     = acc7 ? prod7 : 10'($urandom);
            m7.mul_req_ready = 1'b1;
            acc7 = m7.mul_req_valid;
            if (acc7) begin
                prod7 = m7.mul_u * m7.mul_v;
                q7u.push_back(m7.mul_u);
                q7v.push_back(m7.mul_v);
            end
        end
    end

    // One N=16 operation: drive, wait for accept, measure latency, hold result, handshake
    task automatic op16(input logic [15:0] u, input logic [15:0] v, input logic [31:0] exp,
                        input int stl, input int dly, input int hold,
                        input bit keep, input logic [15:0] nu, input logic [15:0] nv,
                        output int wait_n);
        int lat;
        stall16      = stl;
        dly16        = dly;
        m16.in_valid = 1'b1;
        m16.in_u     = u;
        m16.in_v     = v;
        wait_n       = 0;
        while (!m16.in_ready && wait_n < 50) begin
            @(posedge clk); #1;
            wait_n++;
        end
        chk("accept_timeout", 64'(wait_n < 50), 64'd1);
        @(posedge clk); #1;
        if (keep) begin
            m16.in_u = nu;
            m16.in_v = nv;
        end else begin
            m16.in_valid = 1'b0;
            m16.in_u     = 16'($urandom);
            m16.in_v     = 16'($urandom);
        end
        m16.out_ready = 1'b0;
        lat = 1;
        while (!m16.out_valid && lat < 200) begin
            chk("busy_in_ready", 64'(m16.in_ready), 64'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(8 + stl + 3 * dly));
        for (int i = 0; i < hold; i++) begin
            chk("hold_out_valid", 64'(m16.out_valid), 64'd1);
            chk("hold_out_r", 64'(m16.out_r), 64'(exp));
            chk("hold_in_ready", 64'(m16.in_ready), 64'd0);
            @(posedge clk); #1;
        end
        m16.out_ready = 1'b1;
        chk("out_valid", 64'(m16.out_valid), 64'd1);
        chk("out_r", 64'(m16.out_r), 64'(exp));
        @(posedge clk); #1;
        m16.out_ready = 1'b0;
        chk("idle_in_ready", 64'(m16.in_ready), 64'd1);
        chk("idle_out_valid", 64'(m16.out_valid), 64'd0);
    endtask

    task automatic op7(input logic [6:0] u, input logic [6:0] v);
        int          n;
        int          lat;
        logic [13:0] exp;
        exp         = u * v;
        m7.in_valid = 1'b1;
        m7.in_u     = u;
        m7.in_v     = v;
        n = 0;
        while (!m7.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        m7.in_valid = 1'b0;
        m7.in_u     = 7'($urandom);
        m7.in_v     = 7'($urandom);
        lat = 1;
        while (!m7.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("n7_latency", 64'(lat), 64'd8);
        chk("n7_out_r", 64'(m7.out_r), 64'(exp));
        m7.out_ready = 1'b1;
        @(posedge clk); #1;
        m7.out_ready = 1'b0;
        chk("n7_idle_in_ready", 64'(m7.in_ready), 64'd1);
    endtask

    task automatic chk_reset16(input string tag);
        chk({tag, "_in_ready"}, 64'(m16.in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(m16.out_valid), 64'd0);
        chk({tag, "_req_valid"}, 64'(m16.mul_req_valid), 64'd0);
        chk({tag, "_out_r"}, 64'(m16.out_r), 64'd0);
        chk({tag, "_mul_u"}, 64'(m16.mul_u), 64'd0);
        chk({tag, "_mul_v"}, 64'(m16.mul_v), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          wn;
        int          n;
        logic [15:0] u, v;
        m16.in_valid = 1'b0; m16.in_u = '0; m16.in_v = '0; m16.out_ready = 1'b0;
        m7.in_valid  = 1'b0; m7.in_u  = '0; m7.in_v  = '0; m7.out_ready  = 1'b0;
        #2;
        chk_reset16("por");
        chk("por_n7_in_ready", 64'(m7.in_ready), 64'd1);
        chk("por_n7_out_valid", 64'(m7.out_valid), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // All-ones operands, ideal multiplier, request order
        rq_u.delete(); rq_v.delete();
        op16(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, 0, 0, 0, '0, '0, wn);
        chk("req_count", 64'(rq_u.size()), 64'd3);
        if (rq_u.size() >= 3) begin
            chk("req_x_u", 64'(rq_u[0]), 64'h0FF); chk("req_x_v", 64'(rq_v[0]), 64'h0FF);
            chk("req_y_u", 64'(rq_u[1]), 64'h0FF); chk("req_y_v", 64'(rq_v[1]), 64'h0FF);
            chk("req_z_u", 64'(rq_u[2]), 64'h1FE); chk("req_z_v", 64'(rq_v[2]), 64'h1FE);
        end

        // Request stalled 3 cycles in MUL_X
        op16(16'h1234, 16'hABCD, 32'h0C374FA4, 3, 0, 0, 0, '0, '0, wn);

        // Consumer holds off 5 cycles
        op16(16'hBEEF, 16'h00FF, 32'hBEEF * 32'h00FF, 0, 0, 5, 0, '0, '0, wn);

        // Reset during WAIT_Y, then a stray response arrives
        rq_u.delete(); rq_v.delete();
        stall16 = 0; dly16 = 3;
        m16.in_valid = 1'b1; m16.in_u = 16'h5A5A; m16.in_v = 16'hA5A5;
        @(posedge clk); #1;
        m16.in_valid = 1'b0;
        n = 0;
        while (rq_u.size() < 2 && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        chk("wait_y_reached", 64'(rq_u.size()), 64'd2);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_reset16("mid_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("post_rst_in_ready", 64'(m16.in_ready), 64'd1);
            chk("post_rst_out_valid", 64'(m16.out_valid), 64'd0);
            chk("post_rst_req_valid", 64'(m16.mul_req_valid), 64'd0);
            @(posedge clk); #1;
        end
        dly16 = 0;
        op16(16'd3, 16'd5, 32'd15, 0, 0, 0, 0, '0, '0, wn);

        // Back-to-back with in_valid held high
        op16(16'd2, 16'd3, 32'd6, 0, 0, 0, 1, 16'hFFFF, 16'd1, wn);
        op16(16'hFFFF, 16'd1, 32'h0000FFFF, 0, 0, 0, 0, '0, '0, wn);
        chk("b2b_accept_gap", 64'(wn), 64'd0);

        // Randomized operations
        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 3))
                0:       u = 16'hFFFF;
                1:       u = 16'h0000;
                default: u = 16'($urandom);
            endcase
            v = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
            op16(u, v, 32'(u) * 32'(v), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 3)), 0, '0, '0, wn);
        end

        // Odd width: N=7
        q7u.delete(); q7v.delete();
        op7(7'h7F, 7'h7F);
        chk("n7_max_r", 64'(m7.out_r), 64'h3F01);
        chk("n7_req_count", 64'(q7u.size()), 64'd3);
        if (q7u.size() >= 3) begin
            chk("n7_z_u", 64'(q7u[2]), 64'h16);
            chk("n7_z_v", 64'(q7v[2]), 64'h16);
        end
        for (int k = 0; k < 20; k++) op7(7'($urandom), 7'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
